mem_stage_lsu: RTL and testbench

- Load/store unit in the MEM stage, directly upstream of the MEM/WB pipeline register.
- Converts the EX/MEM access request (memRead/memWrite, funct3, address, store data) into a single-outstanding, ack-based data-memory bus transaction.
- Performs byte-lane alignment, byte enables and load sign/zero extension.
- Produces readD, a one-cycle mem_ready pulse and a pipeline stall consumed by MEM/WB and the hazard unit.

---
 rtl/mem_stage_lsu.sv | 100 ++++++++++
 tb/tb_mem_stage_lsu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a single-outstanding, ack-based data bus
module mem_stage_lsu #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        memRead_In,
   input  logic        memWrite_In,
   input  logic [2:0]  funct3_In,
   input  logic [31:0] addr_In,
   input  logic [31:0] wdata_In,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic [31:0] readD_Out,
   output logic        mem_ready_Out,
   output logic        stall_Out,
   output logic        err_Out
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0] ld_f3;
   logic [1:0] ld_off;
   logic req, legal, fmt_ok, align_ok, timeout;
   logic [3:0] be_n;
   logic [31:0] wd_n, ld_data;
   logic [7:0] rd_byte;
   logic [15:0] rd_half;
   assign req      = memRead_In | memWrite_In;
   assign fmt_ok   = memRead_In ? (funct3_In[1:0] != 2'b11 && !(funct3_In[2] && funct3_In[1]))
                                : (!funct3_In[2] && funct3_In[1:0] != 2'b11);
   assign align_ok = funct3_In[1:0] == 2'b01 ? !addr_In[0] :
                     funct3_In[1:0] == 2'b10 ? addr_In[1:0] == 2'b00 : 1'b1;
   assign legal    = (memRead_In ^ memWrite_In) & fmt_ok & align_ok;
   assign timeout  = cnt == CW'(TIMEOUT_CYCLES - 1);
   assign stall_Out = (state == IDLE && legal) || state == BUSY;
   assign be_n = funct3_In[1:0] == 2'b00 ? 4'b0001 << addr_In[1:0] :
                 funct3_In[1:0] == 2'b01 ? 4'b0011 << addr_In[1:0] : 4'b1111;
   assign wd_n = funct3_In[1:0] == 2'b00 ? {4{wdata_In[7:0]}} :
                 funct3_In[1:0] == 2'b01 ? {2{wdata_In[15:0]}} : wdata_In;
   // load lane selection uses the offset/format captured at request time
   assign rd_byte = bus_rdata[{ld_off, 3'b000} +: 8];
   assign rd_half = bus_rdata[{ld_off[1], 4'b0000} +: 16];
   assign ld_data = ld_f3[1:0] == 2'b00 ? {{24{!ld_f3[2] & rd_byte[7]}}, rd_byte} :
                    ld_f3[1:0] == 2'b01 ? {{16{!ld_f3[2] & rd_half[15]}}, rd_half} : bus_rdata;
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (legal ? BUSY : IDLE) :
                 state == BUSY ? ((bus_ack || timeout) ? DONE : BUSY) : IDLE;
   end
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state         <= IDLE;
         cnt           <= '0;
         ld_f3         <= '0;
         ld_off        <= '0;
         bus_req       <= 1'b0;
         bus_we        <= 1'b0;
         bus_addr      <= '0;
         bus_be        <= '0;
         bus_wdata     <= '0;
         readD_Out     <= '0;
         mem_ready_Out <= 1'b0;
         err_Out       <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= state == BUSY ? cnt + CW'(1) : '0;
         mem_ready_Out <= 1'b0;
         err_Out       <= 1'b0;
         if (state == IDLE && req) begin
            if (legal) begin
               bus_req   <= 1'b1;
               bus_we    <= memWrite_In;
               bus_addr  <= {addr_In[31:2], 2'b00};
               bus_be    <= be_n;
               bus_wdata <= wd_n;
               ld_f3     <= funct3_In;
               ld_off    <= addr_In[1:0];
            end else begin
               err_Out       <= 1'b1;
               mem_ready_Out <= 1'b1;
               readD_Out     <= '0;
            end
         end
         // ack beats a simultaneous timeout expiry
         if (state == BUSY && (bus_ack || timeout)) begin
            bus_req       <= 1'b0;
            mem_ready_Out <= 1'b1;
            err_Out       <= !bus_ack;
            readD_Out     <= (bus_ack && !bus_we) ? ld_data : 32'd0;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks of mem_stage_lsu against a behavioural model
module tb_mem_stage_lsu;
   localparam int T = 4;
   logic clk = 0, rstN = 0;
   logic mem_read = 0, mem_write = 0;
   logic [2:0] funct3 = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic bus_req, bus_we, bus_ack = 0;
   logic [31:0] bus_addr, bus_wdata, bus_rdata = 0, read_d;
   logic [3:0] bus_be;
   logic mem_ready, stall, err;
   int vecs = 0, errs = 0;
   logic [31:0] model_rd = 0;

   mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rstN(rstN), .memRead_In(mem_read), .memWrite_In(mem_write),
      .funct3_In(funct3), .addr_In(addr), .wdata_In(wdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .readD_Out(read_d), .mem_ready_Out(mem_ready), .stall_Out(stall), .err_Out(err)
   );

   always #5 clk = ~clk;

   // k = busy-cycle index (0-based) on which ack is driven; k >= T means never
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdata, input int k, input string nm);
      logic legal, eerr;
      int nb, off, last, stalls;
      logic [3:0] ebe;
      logic [31:0] ewd, v;
      nb = 1 << f3[1:0];
      off = int'(a[1:0]);
      legal = (rd != wr) && (rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2}))
              && (off % nb == 0);
      ebe = nb == 4 ? 4'hF : 4'(((1 << nb) - 1) << off);
      ewd = nb == 1 ? (wd & 32'hFF) * 32'h01010101 : nb == 2 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
      if (nb == 1) begin
         v = (rdata >> (8 * off)) & 32'hFF;
         if (f3 < 4 && v[7]) v = v | 32'hFFFFFF00;
      end else if (nb == 2) begin
         v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
         if (f3 < 4 && v[15]) v = v | 32'hFFFF0000;
      end else v = rdata;
      last = k < T ? k : T - 1;
      eerr = k >= T;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      #1;
      stalls = stall ? 1 : 0;
      vecs++;
      if (stall !== legal) begin errs++; $display("FAIL %s req_stall: got %b want %b", nm, stall, legal); end
      @(posedge clk); #1;
      if (!legal) begin
         vecs++;
         if ({bus_req, err, mem_ready, read_d} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
            errs++; $display("FAIL %s illegal: req/err/rdy/rd got %b %b %b %h want 0 1 1 0", nm, bus_req, err, mem_ready, read_d);
         end
         if (stall) stalls++;
         vecs++;
         if (stalls !== 0) begin errs++; $display("FAIL %s illegal_stall: got %0d cycles want 0", nm, stalls); end
         model_rd = 0;
         mem_read = 0; mem_write = 0;
         @(posedge clk); #1;
      end else begin
         for (int i = 0; i <= last; i++) begin
            vecs++;
            if ({bus_req, bus_we, bus_addr, bus_be, mem_ready} !== {1'b1, wr, a & 32'hFFFFFFFC, ebe, 1'b0}) begin
               errs++; $display("FAIL %s busy%0d: req/we/addr/be/rdy got %b %b %h %b %b want 1 %b %h %b 0",
                                nm, i, bus_req, bus_we, bus_addr, bus_be, mem_ready, wr, a & 32'hFFFFFFFC, ebe);
            end
            if (wr) begin
               vecs++;
               if (bus_wdata !== ewd) begin errs++; $display("FAIL %s wdata: got %h want %h", nm, bus_wdata, ewd); end
            end
            if (stall) stalls++;
            bus_ack = (i == k);
            bus_rdata = (i == k) ? rdata : $urandom;
            @(posedge clk); #1;
         end
         bus_ack = 0;
         model_rd = (eerr || wr) ? 32'd0 : v;
         vecs++;
         if ({bus_req, mem_ready, err, stall, read_d} !== {1'b0, 1'b1, eerr, 1'b0, model_rd}) begin
            errs++; $display("FAIL %s done: req/rdy/err/stall/rd got %b %b %b %b %h want 0 1 %b 0 %h",
                             nm, bus_req, mem_ready, err, stall, read_d, eerr, model_rd);
         end
         vecs++;
         if (stalls !== last + 2) begin errs++; $display("FAIL %s stall_len: got %0d want %0d", nm, stalls, last + 2); end
         @(posedge clk); #1;
         mem_read = 0; mem_write = 0;
      end
      vecs++;
      if ({bus_req, mem_ready, err, read_d} !== {1'b0, 1'b0, 1'b0, model_rd}) begin
         errs++; $display("FAIL %s after: req/rdy/err/rd got %b %b %b %h want 0 0 0 %h", nm, bus_req, mem_ready, err, read_d, model_rd);
      end
   endtask

   task automatic test_reset();
      #1;
      vecs++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, read_d, mem_ready, stall, err} !== '0) begin
         errs++; $display("FAIL reset: req %b we %b addr %h be %b wd %h rd %h rdy %b stall %b err %b want all 0",
                          bus_req, bus_we, bus_addr, bus_be, bus_wdata, read_d, mem_ready, stall, err);
      end
      @(posedge clk); #1;
      rstN = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      do_access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 2, "lw");
      do_access(1, 0, 3'b000, 32'h203, 0, 32'h80123456, 0, "lb");
      do_access(1, 0, 3'b100, 32'h203, 0, 32'h80123456, 1, "lbu");
      do_access(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 0, 1, "sh");
      do_access(1, 0, 3'b010, 32'h101, 0, 0, 0, "lw_misaligned");
      do_access(1, 0, 3'b001, 32'h0F6, 0, 32'h1234F678, 0, "lh_hi");
      do_access(1, 0, 3'b101, 32'h0F6, 0, 32'h8234F678, 0, "lhu_hi");
      do_access(0, 1, 3'b000, 32'h011, 32'h12345678, 0, 0, "sb");
      do_access(0, 1, 3'b100, 32'h010, 0, 0, 0, "store_bad_f3");
      do_access(1, 1, 3'b010, 32'h010, 0, 0, 0, "read_and_write");
   endtask

   task automatic test_timeout();
      do_access(1, 0, 3'b010, 32'h400, 0, 32'h11111111, 99, "timeout");
      do_access(1, 0, 3'b010, 32'h404, 0, 32'h22222222, T - 1, "ack_at_limit");
   endtask

   task automatic test_stray_ack();
      for (int i = 0; i < 3; i++) begin
         bus_ack = 1; bus_rdata = $urandom;
         @(posedge clk); #1;
         vecs++;
         if ({bus_req, mem_ready, err, read_d} !== {1'b0, 1'b0, 1'b0, model_rd}) begin
            errs++; $display("FAIL stray_ack: req/rdy/err/rd got %b %b %b %h want 0 0 0 %h", bus_req, mem_ready, err, read_d, model_rd);
         end
      end
      bus_ack = 0;
   endtask

   task automatic test_reset_busy();
      mem_read = 1; funct3 = 3'b010; addr = 32'h40;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstN = 0; mem_read = 0;
      #1;
      vecs++;
      if ({bus_req, stall, mem_ready, err, read_d} !== '0) begin
         errs++; $display("FAIL reset_busy: req/stall/rdy/err/rd got %b %b %b %b %h want all 0", bus_req, stall, mem_ready, err, read_d);
      end
      model_rd = 0;
      @(posedge clk); #1;
      rstN = 1;
      bus_ack = 1; bus_rdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus_ack = 0;
      vecs++;
      if ({bus_req, mem_ready, err, read_d} !== '0) begin
         errs++; $display("FAIL late_ack: req/rdy/err/rd got %b %b %b %h want all 0", bus_req, mem_ready, err, read_d);
      end
      do_access(1, 0, 3'b010, 32'h40, 0, 32'h0BADC0DE, 1, "lw_after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int op;
         op = $urandom_range(0, 5);
         do_access(op <= 2 || op == 5, op >= 3, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 5), "rand");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_stray_ack();
      test_reset_busy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
